// File: rtl/noc_pkg.sv
// Constants and types shared between the flit injector and the router arbiter/timer.
// The flit_id codes must stay bit-identical to the ones the arbiter's timer decodes.
package noc_pkg;

    localparam int LEN_W = 12;

    localparam logic [2:0] FLIT_IDLE = 3'b000;
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BODY,
        ST_TAIL
    } inj_state_e;

endpackage

// File: rtl/flit_injector_if.sv
// Descriptor, payload, arbiter and flit-output signals of one router input port.
// The master modport is the injector side; the slave modport is the environment side.
interface flit_injector_if #(
    parameter int DATA_W = 32
);
    import noc_pkg::*;

    logic              pkt_valid;
    logic              pkt_ready;
    logic [LEN_W-1:0]  pkt_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              grant;
    logic              flit_valid;
    logic [2:0]        flit_id;
    logic [DATA_W-1:0] flit_data;
    logic [LEN_W-1:0]  length;

    modport master (
        input  pkt_valid, pkt_len, in_valid, in_data, grant,
        output pkt_ready, in_ready, req, flit_valid, flit_id, flit_data, length
    );

    modport slave (
        output pkt_valid, pkt_len, in_valid, in_data, grant,
        input  pkt_ready, in_ready, req, flit_valid, flit_id, flit_data, length
    );

endinterface

// File: rtl/flit_injector.sv
// Requester-side packet injector: latches a descriptor, requests the arbiter and streams
// header/body/tail flits while granted, stalling in place whenever the grant is withdrawn.
module flit_injector
    import noc_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int TIMEOUT_SLACK = 2
) (
    input  logic           clk,
    input  logic           rst,
    flit_injector_if.master bus
);

    inj_state_e       state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rem_q;
    logic             req_q;

    logic             accept;
    logic [LEN_W-1:0] len_acc;
    logic             beat;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        logic [LEN_W:0] s;
        s = {1'b0, l} + (LEN_W+1)'(TIMEOUT_SLACK);
        return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
    endfunction

    assign accept  = (state_q == ST_IDLE) && bus.pkt_valid;
    assign len_acc = (bus.pkt_len < LEN_W'(2)) ? LEN_W'(2) : bus.pkt_len;
    // A payload beat moves only when the arbiter grants us and a word is offered.
    assign beat    = req_q && bus.grant && bus.in_valid;

    assign bus.pkt_ready = (state_q == ST_IDLE);
    assign bus.req       = req_q;
    assign bus.length    = (state_q == ST_IDLE) ? '0 : sat_len(len_q);

    always_comb begin
        bus.flit_valid = 1'b0;
        bus.flit_id    = FLIT_IDLE;
        bus.flit_data  = '0;
        bus.in_ready   = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (req_q && bus.grant) begin
                    bus.flit_valid = 1'b1;
                    bus.flit_id    = FLIT_HEAD;
                    bus.flit_data  = DATA_W'(len_q);
                end
            end
            ST_BODY, ST_TAIL: begin
                if (beat) begin
                    bus.flit_valid = 1'b1;
                    bus.flit_id    = (state_q == ST_BODY) ? FLIT_BODY : FLIT_TAIL;
                    bus.flit_data  = bus.in_data;
                    bus.in_ready   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        rem_q   <= len_acc - LEN_W'(1);
                    end
                end
                ST_REQ: begin
                    if (bus.grant) begin
                        state_q <= (rem_q == LEN_W'(1)) ? ST_TAIL : ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (beat) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(2)) begin
                            state_q <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (beat) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        rem_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Length is only observed outside IDLE, so the latch needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q <= len_acc;
        end
    end

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: per-cycle expected flit/handshake values written by hand.
module tb_flit_injector;
    import noc_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    flit_injector_if #(.DATA_W(32)) bus ();

    flit_injector #(.DATA_W(32), .TIMEOUT_SLACK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".pkt_ready"},  32'(bus.pkt_ready),  32'd1);
        chk({tag, ".req"},        32'(bus.req),        32'd0);
        chk({tag, ".flit_valid"}, 32'(bus.flit_valid), 32'd0);
        chk({tag, ".flit_id"},    32'(bus.flit_id),    32'(FLIT_IDLE));
        chk({tag, ".flit_data"},  bus.flit_data,       32'd0);
        chk({tag, ".length"},     32'(bus.length),     32'd0);
        chk({tag, ".in_ready"},   32'(bus.in_ready),   32'd0);
    endtask

    // One clock: drive inputs just after the edge, check mid-cycle, advance to next edge.
    task automatic cyc(input string tag, input logic g, input logic iv, input logic [31:0] din,
                       input logic ev, input logic [2:0] eid, input logic [31:0] ed,
                       input logic eir, input logic ereq, input logic erdy, input logic [11:0] elen);
        bus.grant    = g;
        bus.in_valid = iv;
        bus.in_data  = din;
        #4;
        chk({tag, ".flit_valid"}, 32'(bus.flit_valid), 32'(ev));
        chk({tag, ".flit_id"},    32'(bus.flit_id),    32'(eid));
        if (ev) chk({tag, ".flit_data"}, bus.flit_data, ed);
        chk({tag, ".in_ready"},   32'(bus.in_ready),   32'(eir));
        chk({tag, ".req"},        32'(bus.req),        32'(ereq));
        chk({tag, ".pkt_ready"},  32'(bus.pkt_ready),  32'(erdy));
        chk({tag, ".length"},     32'(bus.length),     32'(elen));
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [11:0] len);
        bus.pkt_valid = 1'b1;
        bus.pkt_len   = len;
        cyc({tag, ".acc"}, 1'b1, 1'b1, 32'hdead, 1'b0, FLIT_IDLE, 32'd0, 1'b0, 1'b0, 1'b1, 12'd0);
        bus.pkt_valid = 1'b0;
        bus.pkt_len   = 12'd0;
    endtask

    initial begin
        int nbody;
        int nother;
        bit seen_tail;
        logic [11:0] tail_len;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.pkt_len   = 12'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.grant     = 1'b0;
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // pkt_len=4, grant and in_valid held high
        accept("p4", 12'd4);
        cyc("p4.head", 1, 1, 32'hA0, 1, FLIT_HEAD, 32'd4,  0, 1, 0, 12'd6);
        cyc("p4.b0",   1, 1, 32'hA0, 1, FLIT_BODY, 32'hA0, 1, 1, 0, 12'd6);
        cyc("p4.b1",   1, 1, 32'hA1, 1, FLIT_BODY, 32'hA1, 1, 1, 0, 12'd6);
        cyc("p4.tail", 1, 1, 32'hA2, 1, FLIT_TAIL, 32'hA2, 1, 1, 0, 12'd6);
        cyc("p4.idle", 1, 1, 32'hA3, 0, FLIT_IDLE, 32'd0,  0, 0, 1, 12'd0);

        // pkt_len=1 clamps to 2: header then tail
        accept("p1", 12'd1);
        cyc("p1.head", 1, 1, 32'hB0, 1, FLIT_HEAD, 32'd2,  0, 1, 0, 12'd4);
        cyc("p1.tail", 1, 1, 32'hB0, 1, FLIT_TAIL, 32'hB0, 1, 1, 0, 12'd4);
        cyc("p1.idle", 1, 1, 32'hB1, 0, FLIT_IDLE, 32'd0,  0, 0, 1, 12'd0);

        // pkt_len=6 with grant withdrawn for 3 cycles after the 2nd body flit
        accept("p6", 12'd6);
        cyc("p6.head", 1, 1, 32'hC0, 1, FLIT_HEAD, 32'd6,  0, 1, 0, 12'd8);
        cyc("p6.b0",   1, 1, 32'hC0, 1, FLIT_BODY, 32'hC0, 1, 1, 0, 12'd8);
        cyc("p6.b1",   1, 1, 32'hC1, 1, FLIT_BODY, 32'hC1, 1, 1, 0, 12'd8);
        cyc("p6.gap0", 0, 1, 32'hC2, 0, FLIT_IDLE, 32'd0,  0, 1, 0, 12'd8);
        cyc("p6.gap1", 0, 1, 32'hC2, 0, FLIT_IDLE, 32'd0,  0, 1, 0, 12'd8);
        cyc("p6.gap2", 0, 1, 32'hC2, 0, FLIT_IDLE, 32'd0,  0, 1, 0, 12'd8);
        cyc("p6.b2",   1, 1, 32'hC2, 1, FLIT_BODY, 32'hC2, 1, 1, 0, 12'd8);
        cyc("p6.b3",   1, 1, 32'hC3, 1, FLIT_BODY, 32'hC3, 1, 1, 0, 12'd8);
        cyc("p6.tail", 1, 1, 32'hC4, 1, FLIT_TAIL, 32'hC4, 1, 1, 0, 12'd8);
        cyc("p6.idle", 1, 1, 32'hC5, 0, FLIT_IDLE, 32'd0,  0, 0, 1, 12'd0);

        // pkt_len=5 with in_valid low for 2 cycles mid-body
        accept("p5", 12'd5);
        cyc("p5.head", 1, 1, 32'h1000, 1, FLIT_HEAD, 32'd5,    0, 1, 0, 12'd7);
        cyc("p5.b0",   1, 1, 32'h1000, 1, FLIT_BODY, 32'h1000, 1, 1, 0, 12'd7);
        cyc("p5.bub0", 1, 0, 32'h1001, 0, FLIT_IDLE, 32'd0,    0, 1, 0, 12'd7);
        cyc("p5.bub1", 1, 0, 32'h1001, 0, FLIT_IDLE, 32'd0,    0, 1, 0, 12'd7);
        cyc("p5.b1",   1, 1, 32'h1001, 1, FLIT_BODY, 32'h1001, 1, 1, 0, 12'd7);
        cyc("p5.b2",   1, 1, 32'h1002, 1, FLIT_BODY, 32'h1002, 1, 1, 0, 12'd7);
        cyc("p5.tail", 1, 1, 32'h1003, 1, FLIT_TAIL, 32'h1003, 1, 1, 0, 12'd7);
        cyc("p5.idle", 0, 0, 32'h0,    0, FLIT_IDLE, 32'd0,    0, 0, 1, 12'd0);

        // pkt_len=4095: saturating length, tail exactly at flit 4095
        accept("pmax", 12'd4095);
        cyc("pmax.head", 1, 1, 32'd0, 1, FLIT_HEAD, 32'd4095, 0, 1, 0, 12'd4095);
        nbody = 0;
        nother = 0;
        seen_tail = 1'b0;
        tail_len = 12'd0;
        for (int k = 0; k < 5000 && !seen_tail; k++) begin
            bus.grant    = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(k);
            #4;
            if (bus.flit_id == FLIT_BODY) nbody++;
            else if (bus.flit_id == FLIT_TAIL) begin
                seen_tail = 1'b1;
                tail_len  = bus.length;
            end else nother++;
            @(posedge clk);
            #1;
        end
        chk("pmax.tail_seen",  32'(seen_tail), 32'd1);
        chk("pmax.body_count", 32'(nbody),     32'd4093);
        chk("pmax.other",      32'(nother),    32'd0);
        chk("pmax.tail_len",   32'(tail_len),  32'd4095);
        cyc("pmax.idle", 1, 1, 32'd0, 0, FLIT_IDLE, 32'd0, 0, 0, 1, 12'd0);

        // asynchronous reset in the body of a 5-flit packet
        accept("pr", 12'd5);
        cyc("pr.head", 1, 1, 32'hE0, 1, FLIT_HEAD, 32'd5,  0, 1, 0, 12'd7);
        cyc("pr.b0",   1, 1, 32'hE0, 1, FLIT_BODY, 32'hE0, 1, 1, 0, 12'd7);
        bus.grant    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hE1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("pr.abort");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("pr.idle", 1, 1, 32'hE1, 0, FLIT_IDLE, 32'd0, 0, 0, 1, 12'd0);
        accept("pn", 12'd3);
        cyc("pn.head", 1, 1, 32'hF0, 1, FLIT_HEAD, 32'd3,  0, 1, 0, 12'd5);
        cyc("pn.b0",   1, 1, 32'hF0, 1, FLIT_BODY, 32'hF0, 1, 1, 0, 12'd5);
        cyc("pn.tail", 1, 1, 32'hF1, 1, FLIT_TAIL, 32'hF1, 1, 1, 0, 12'd5);
        cyc("pn.idle", 0, 0, 32'h0,  0, FLIT_IDLE, 32'd0,  0, 0, 1, 12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
